// File: rtl/seg7_pkg.sv
// Shared segment constants, slot/value types and the BCD-to-segment lookup
// for the seg7_temp_scan display driver.
package seg7_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_C    = 7'b0111001;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    SLOT_C        = 2'd0,
    SLOT_UNITS    = 2'd1,
    SLOT_TENS     = 2'd2,
    SLOT_HUNDREDS = 2'd3
  } slot_t;

  typedef struct packed {
    logic [1:0] cent;
    logic [3:0] dix;
    logic [3:0] unite;
  } bcd_val_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  function automatic slot_t next_slot(input slot_t s);
    return slot_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/seg7_temp_scan_if.sv
// Bundle between the BCD producer and the 7-segment scanner: update strobe
// with digits in, segment/anode/frame outputs back.
interface seg7_temp_scan_if;
  logic       upd;
  logic [3:0] unite;
  logic [3:0] dix;
  logic [1:0] cent;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  modport master (
    output upd, unite, dix, cent,
    input  seg, an, frame
  );

  modport slave (
    input  upd, unite, dix, cent,
    output seg, an, frame
  );
endinterface

// File: rtl/seg7_enc.sv
// Combinational BCD digit to active-high 7-segment pattern, with a blank
// override that turns every segment off.
module seg7_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : bcd_to_seg(bcd);
  end

endmodule

// File: rtl/seg7_temp_scan.sv
// 4-digit common-anode scanner showing "HTU C" with frame-aligned updates and
// per-slot dead time. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_temp_scan
  import seg7_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_CYC   = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_temp_scan_if.slave bus
);

  localparam int PW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam int DW = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYC);
  localparam logic [6:0]    SEG_IDLE  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_IDLE   = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PW-1:0] presc_reg, presc_next;
  slot_t         idx_reg, idx_next;
  logic [DW-1:0] dead_reg, dead_next;
  logic          run_reg, run_next;
  bcd_val_t      disp_reg, disp_next;
  bcd_val_t      pend_val_reg, pend_val_next;
  logic          pend_reg, pend_next;
  logic          frame_reg, frame_next;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;

  logic          tick;
  logic          boundary;
  bcd_val_t      in_val;
  logic [3:0]    enc_digit;
  logic          enc_blank;
  logic [6:0]    enc_seg;
  logic [6:0]    pattern;
  logic [3:0]    an_onehot;

  assign in_val   = {bus.cent, bus.dix, bus.unite};
  assign tick     = (presc_reg == PRESC_MAX);
  assign boundary = tick && (idx_reg == SLOT_HUNDREDS);

  // Scan timing
  always_comb begin
    presc_next = tick ? '0 : presc_reg + 1'b1;
    idx_next   = tick ? next_slot(idx_reg) : idx_reg;
    if (tick) begin
      dead_next = DEAD_INIT;
    end else if (dead_reg != '0) begin
      dead_next = dead_reg - 1'b1;
    end else begin
      dead_next = '0;
    end
    // The slot interrupted by reset stays dark; lighting starts at the first tick
    run_next   = run_reg | tick;
    frame_next = boundary;
  end

  // Shadow register: digits only reach the display at a frame boundary
  always_comb begin
    disp_next     = disp_reg;
    pend_val_next = pend_val_reg;
    pend_next     = pend_reg;
    if (boundary) begin
      if (bus.upd) begin
        disp_next = in_val;
      end else if (pend_reg) begin
        disp_next = pend_val_reg;
      end
      pend_next = 1'b0;
    end else if (bus.upd) begin
      pend_val_next = in_val;
      pend_next     = 1'b1;
    end
  end

  // Digit for the slot about to start
  always_comb begin
    case (idx_next)
      SLOT_UNITS:    enc_digit = disp_reg.unite;
      SLOT_TENS:     enc_digit = disp_reg.dix;
      SLOT_HUNDREDS: enc_digit = {2'b00, disp_reg.cent};
      default:       enc_digit = disp_reg.unite;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign enc_blank = (disp_reg.cent == 2'd0) &&
                     ((idx_next == SLOT_HUNDREDS) ||
                      ((idx_next == SLOT_TENS) && (disp_reg.dix == 4'd0)));
`else
  assign enc_blank = 1'b0;
`endif

  seg7_enc u_enc (
    .bcd   (enc_digit),
    .blank (enc_blank),
    .seg   (enc_seg)
  );

  assign pattern = (idx_next == SLOT_C) ? SEG_C : enc_seg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_onehot[gi] = (idx_next == 2'(gi));
  end

  always_comb begin
    seg_next = tick ? (ACTIVE_LOW ? ~pattern : pattern) : seg_reg;
    if (run_next && (dead_next == '0)) begin
      an_next = ACTIVE_LOW ? ~an_onehot : an_onehot;
    end else begin
      an_next = AN_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      idx_reg      <= SLOT_C;
      dead_reg     <= DEAD_INIT;
      run_reg      <= 1'b0;
      disp_reg     <= '0;
      pend_val_reg <= '0;
      pend_reg     <= 1'b0;
      frame_reg    <= 1'b0;
      seg_reg      <= SEG_IDLE;
      an_reg       <= AN_IDLE;
    end else begin
      presc_reg    <= presc_next;
      idx_reg      <= idx_next;
      dead_reg     <= dead_next;
      run_reg      <= run_next;
      disp_reg     <= disp_next;
      pend_val_reg <= pend_val_next;
      pend_reg     <= pend_next;
      frame_reg    <= frame_next;
      seg_reg      <= seg_next;
      an_reg       <= an_next;
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.an    = an_reg;
  assign bus.frame = frame_reg;

endmodule

// File: tb/tb_seg7_temp_scan.sv
// Directed bench for seg7_temp_scan (TICK_DIV=4, DEAD_CYC=1, active-high);
// outputs are sampled on the falling edge, one line printed per scanned slot.
module tb_seg7_temp_scan;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S9 = 7'b1101111;
  localparam logic [6:0] SC = 7'b0111001;
  localparam logic [6:0] SD = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  seg7_temp_scan_if bus ();

  seg7_temp_scan #(
    .TICK_DIV   (4),
    .DEAD_CYC   (1),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.upd = 1'b0;
  endtask

  task automatic send_upd(input logic [1:0] c, input logic [3:0] d, input logic [3:0] u);
    bus.upd   = 1'b1;
    bus.cent  = c;
    bus.dix   = d;
    bus.unite = u;
  endtask

  // Called on the last cycle before the slot starts; covers its 4 cycles
  task automatic check_slot(input string tag, input int s, input logic [6:0] exp_seg,
                            input logic exp_frame);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    step();
    chk({tag, "_dark_an"}, {4'b0, bus.an}, 8'h00);
    chk({tag, "_dark_seg"}, {1'b0, bus.seg}, {1'b0, exp_seg});
    chk({tag, "_frame"}, {7'b0, bus.frame}, {7'b0, exp_frame});
    step();
    chk({tag, "_lit_frame"}, {7'b0, bus.frame}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk({tag, "_lit_an"}, {4'b0, bus.an}, {4'b0, oh});
      chk({tag, "_lit_seg"}, {1'b0, bus.seg}, {1'b0, exp_seg});
    end
    $display("slot %s idx=%0d an=%b seg=%b", tag, s, bus.an, bus.seg);
  endtask

  task automatic check_frame(input string tag, input logic [6:0] u, input logic [6:0] t,
                             input logic [6:0] h);
    check_slot({tag, "_c"}, 0, SC, 1'b1);
    check_slot({tag, "_u"}, 1, u, 1'b0);
    check_slot({tag, "_t"}, 2, t, 1'b0);
    check_slot({tag, "_h"}, 3, h, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.upd   = 1'b0;
    bus.unite = 4'd0;
    bus.dix   = 4'd0;
    bus.cent  = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_an", {4'b0, bus.an}, 8'h00);
    chk("rst_seg", {1'b0, bus.seg}, 8'h00);
    chk("rst_frame", {7'b0, bus.frame}, 8'h00);
    rst_n = 1'b1;

    // Slot interrupted by reset stays dark, scan then runs idx1,2,3
    for (int i = 0; i < 3; i++) begin
      step();
      chk("boot_dark_an", {4'b0, bus.an}, 8'h00);
    end
    check_slot("boot_u", 1, S0, 1'b0);
    check_slot("boot_t", 2, LZ, 1'b0);
    check_slot("boot_h", 3, LZ, 1'b0);
    check_frame("idle", S0, LZ, LZ);

    // Mid-frame update is held until the boundary
    check_slot("b_c", 0, SC, 1'b1);
    check_slot("b_u", 1, S0, 1'b0);
    send_upd(2'd1, 4'd2, 4'd5);
    check_slot("b_t", 2, LZ, 1'b0);
    check_slot("b_h", 3, LZ, 1'b0);
    check_frame("v125", S5, S2, S1);

    // Two updates in one frame: last wins
    check_slot("d_c", 0, SC, 1'b1);
    send_upd(2'd1, 4'd2, 4'd3);
    check_slot("d_u", 1, S5, 1'b0);
    send_upd(2'd0, 4'd4, 4'd5);
    check_slot("d_t", 2, S2, 1'b0);
    check_slot("d_h", 3, S1, 1'b0);
    check_frame("v045", S5, S4, LZ);

    // Update on the boundary cycle goes straight to display, nothing left pending
    send_upd(2'd2, 4'd0, 4'd9);
    check_frame("v209", S9, S0, S2);
    check_slot("g_c", 0, SC, 1'b1);
    check_slot("g_u", 1, S9, 1'b0);
    check_slot("g_t", 2, S0, 1'b0);
    send_upd(2'd0, 4'd3, 4'hA);
    check_slot("g_h", 3, S2, 1'b0);
    check_frame("v03A", SD, S3, LZ);

    // Reset while an[2] is lit, with an update pending
    check_slot("r_c", 0, SC, 1'b1);
    send_upd(2'd2, 4'd8, 4'd8);
    check_slot("r_u", 1, SD, 1'b0);
    step();
    chk("r_t_dark_an", {4'b0, bus.an}, 8'h00);
    step();
    chk("r_t_lit_an", {4'b0, bus.an}, 8'h04);
    chk("r_t_lit_seg", {1'b0, bus.seg}, {1'b0, S3});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {4'b0, bus.an}, 8'h00);
    chk("async_rst_seg", {1'b0, bus.seg}, 8'h00);
    chk("async_rst_frame", {7'b0, bus.frame}, 8'h00);
    step();
    chk("held_rst_an", {4'b0, bus.an}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_dark_an", {4'b0, bus.an}, 8'h00);
    end
    step();
    chk("post_first_an", {4'b0, bus.an}, 8'h02);
    chk("post_first_seg", {1'b0, bus.seg}, {1'b0, S0});
    step();
    step();
    check_slot("post_t", 2, LZ, 1'b0);
    check_slot("post_h", 3, LZ, 1'b0);
    check_frame("post", S0, LZ, LZ);

    // Leading-zero case 007
    check_slot("lz_c", 0, SC, 1'b1);
    send_upd(2'd0, 4'd0, 4'd7);
    check_slot("lz_u", 1, S0, 1'b0);
    check_slot("lz_t", 2, LZ, 1'b0);
    check_slot("lz_h", 3, LZ, 1'b0);
    check_frame("v007", S7, LZ, LZ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
